rf_wb_arbiter: RTL

Write-port arbiter for the core register file. The register file has a single write port. Three sources compete for it: the pipeline writeback stage (W), asynchronous load returns from the memory unit, and the host R0 initialisation path. The block buffers load returns in a small FIFO, grants the port one source per cycle, resolves write-after-write conflicts against W, and raises a stall request when a buffered load has waited too long.

---
 rtl/rf_wb_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: W stage, buffered load returns, R0 init.
// Loads wait in a small FIFO; W always wins and kills older same-dst loads.
module rf_wb_arbiter #(
    parameter int REG_WIDTH     = 8,
    parameter int REG_PTR_WIDTH = 4,
    parameter int DEPTH         = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_valid,
    input  logic [REG_PTR_WIDTH-1:0] wb_dst,
    input  logic [REG_WIDTH-1:0]     wb_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [REG_PTR_WIDTH-1:0] ld_dst,
    input  logic [REG_WIDTH-1:0]     ld_data,
    input  logic                     init_valid,
    output logic                     init_ready,
    input  logic [REG_WIDTH-1:0]     init_data,
    output logic                     rf_we,
    output logic [REG_PTR_WIDTH-1:0] rf_dst,
    output logic [REG_WIDTH-1:0]     rf_data,
    output logic                     stall_req,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LIMIT_C = AW'(STARVE_LIMIT);

    logic [REG_PTR_WIDTH-1:0] dst_q  [DEPTH];
    logic [REG_WIDTH-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [AW-1:0]            age_q, age_d;

    logic empty;
    logic head_vld;
    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign head_vld = !empty && vld_q[rd_ptr_q];
    assign ld_ready = reset_n && (count_q < DEPTH_C);
    assign push     = ld_valid && ld_ready;
    // The head leaves whenever W is idle: written if valid, dropped if killed.
    assign pop      = reset_n && !empty && !wb_valid;

    assign busy      = !empty;
    assign stall_req = reset_n && !empty && (age_q == LIMIT_C);

    // Fixed-priority grant of the single write port: W, FIFO head, R0 init.
    always_comb begin
        rf_we      = 1'b0;
        rf_dst     = '0;
        rf_data    = '0;
        init_ready = 1'b0;
        if (reset_n) begin
            if (wb_valid) begin
                rf_we   = 1'b1;
                rf_dst  = wb_dst;
                rf_data = wb_data;
            end else if (head_vld) begin
                rf_we   = 1'b1;
                rf_dst  = dst_q[rd_ptr_q];
                rf_data = data_q[rd_ptr_q];
            end else if (empty && init_valid) begin
                rf_we      = 1'b1;
                init_ready = 1'b1;
            end
            if (init_ready) begin
                rf_dst  = '0;
                rf_data = init_data;
            end
        end
    end

    // Next-state for valid bits, pointers, occupancy and head age.
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && (dst_q[i] == wb_dst)) begin
                vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wr_ptr_q] = !(wb_valid && (ld_dst == wb_dst));
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        age_d = age_q;
        if (empty || pop) begin
            age_d = '0;
        end else if (age_q != LIMIT_C) begin
            age_d = age_q + 1'b1;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
        end
    end

    // Payload storage; only written on an accepted load.
    always_ff @(posedge clk) begin
        if (push) begin
            dst_q[wr_ptr_q]  <= ld_dst;
            data_q[wr_ptr_q] <= ld_data;
        end
    end

endmodule
